cim_gemv_seq: RTL and testbench
===============================

# cim_gemv_seq

Sequencer for the 8-column compute-in-memory GeMM macro. On each command it runs one matrix-vector pass:
- clears the macro's eight accumulators;
- streams K packed input words (eight 4-bit activations each) into the macro in accumulate mode;
- drains the eight accumulated column results as a valid/ready stream.

It sits between the core's CIM command/operand path and the macro, and it owns the macro's `cs`, `write`, `cim`, `partial_sum`, `reset_output`, `output_reg`, `address` and `input_data` pins during a pass.

## Interface

Parameters:
- `K_WIDTH`, 5: width of the chunk-count field. Legal K is 0..16, because 128 rows are consumed 8 per chunk.
- `NUM_OUT`, 8: number of macro output registers drained per pass. Fixed at 8.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: command strobe. Sampled only in IDLE; ignored otherwise.
- `base_addr` in 7: row offset of the first chunk. Sampled with `start`.
- `k_chunks` in K_WIDTH: number of input words in the pass. Sampled with `start`; values above 16 are clamped to 16.
- `abort` in 1: synchronous cancel. Highest priority.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32: activation word stream. Nibble [31:28] is row +0 and nibble [3:0] is row +7.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 32, `out_idx` out 3: result stream.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a pass completes.
- `cim_cs`, `cim_write`, `cim_en`, `cim_psum`, `cim_reset_out` out 1 each: macro controls.
- `cim_output_reg` out 4: macro output select.
- `cim_address` out 32: macro address.
- `cim_input_data` out 32: macro input data.
- `cim_result` in 32: the macro's `cim_output`.

## Operation

State machine: IDLE → CLEAR → ACCUM → DRAIN → DONE → IDLE.

Macro contract, with `cs`=1, `write`=0, `cim`=1 at a clock edge:
- `reset_output`=1 zeroes all 8 accumulators.
- Otherwise, each accumulator adds its column's 6-bit sign-extended ADC value if `partial_sum`=1.
- `cim_output` is a combinational mux of the accumulator chosen by `output_reg` while `cim`=1.

IDLE:
- All macro outputs are 0.
- `start`=1 latches `base_addr` and the clamped K, clears the chunk counter `idx`, and moves to CLEAR.

CLEAR (exactly 1 cycle):
- Drives `cim_cs`=1, `cim_en`=1, `cim_reset_out`=1, `cim_psum`=0.
- Next state is ACCUM, or DRAIN if K=0.

ACCUM:
- `in_ready`=1, `cim_en`=1.
- `cim_address` = {25'b0, (base + 8·idx) mod 128}. The 7-bit sum wraps past 127.
- `cim_input_data` = `in_data`.
- `cim_cs` and `cim_psum` equal `in_valid` (combinational), so the macro only accumulates on a handshake.
- Each handshake increments `idx`. The handshake with `idx`=K−1 moves to DRAIN.

DRAIN:
- `cim_cs`=0 (no accumulation), `cim_en`=1.
- `cim_output_reg` = {1'b0, `j`}, where `j` is the drain counter, starting at 0.
- `out_valid`=1, `out_data`=`cim_result`, `out_idx`=`j`.
- Each out handshake increments `j`. The handshake at `j`=7 moves to DONE.
- `out_data` and `out_idx` hold stable while `out_valid`=1 and `out_ready`=0.

DONE (1 cycle):
- `done`=1, all macro outputs are 0.
- Next state is IDLE.

Invariants:
- `cim_write` is always 0; weight loading is not this block's job.
- `cim_reset_out` is 1 only in CLEAR.

Abort:
- In any non-IDLE state, `abort`=1 returns the FSM to IDLE at the next edge.
- No `done` pulse is produced.
- Combinational outputs are forced low in the abort cycle: `in_ready`, `out_valid`, `cim_cs`, `cim_psum`. Nothing is consumed or accumulated that cycle.

Simultaneous events:
- `start` together with `abort` in IDLE: `abort` wins and the start is dropped.
- `start` in DONE: ignored.

## Timing

- Reset values (async assert): state IDLE, `idx`=0, `j`=0, and every output 0 (`busy`, `done`, `in_ready`, `out_valid`, all `cim_*`, `out_data`, `out_idx`).
- Reset asserted mid-pass drops the pass immediately. The macro accumulators are left as they are; the next pass's CLEAR zeroes them.
- `start` accepted at edge T: CLEAR is active in cycle T..T+1, and the first ACCUM cycle follows.
- Minimum pass length, with full-throughput handshakes: 1 (CLEAR) + K + 8 (DRAIN) + 1 (DONE) cycles. For K=16 this is 26 cycles.
- Back-to-back passes: `start` is accepted in the IDLE cycle that immediately follows DONE.
- `busy` is registered from state. `in_ready`, `out_valid` and all `cim_*` outputs are decoded from registered state and counters, plus `in_valid`/`abort` where stated above.
- `out_data` is a combinational path from `cim_result`. The macro mux is stable because `output_reg` is registered.

## Test plan

- **Reset and idle.** Assert `rst_n`=0 mid-ACCUM, then release → all outputs are 0, `busy`=0, and the next `start` begins with the CLEAR pulse (`cim_reset_out`=1 for exactly 1 cycle).
- **Addressing with stalls.** `base_addr`=0x10, K=3, `in_valid` toggling 1,0,1,0,1 → `cim_psum`=1 on exactly 3 edges, with addresses 0x10, 0x18, 0x20 and matching `in_data`; DRAIN is entered after the third handshake.
- **Wrap-around.** `base_addr`=0x78, K=2 → addresses 0x78 then 0x00. K=20 → clamped to 16 handshakes.
- **End-to-end with a macro model.** All weights in column 3 = 0x40, column 0 = 0; 2 words of all-0xF nibbles → column 3 raw sum 2×8×15×64 = 15360 → [14:9] = 0x1E → `out_data`=30 at `out_idx`=3, 0 at `out_idx`=0. A second pass returns the same values, proving CLEAR works.
- **Drain backpressure.** `out_ready` low for 4 cycles at `j`=2 → `out_idx`/`out_data` held stable; exactly 8 beats, indexes 0..7 in order; `done` pulses once.
- **Abort and K=0.** `abort` in ACCUM after 1 of 4 handshakes → IDLE next edge, no `done`, no `cim_cs` in the abort cycle. K=0 → CLEAR then DRAIN, eight beats of zeros, total 10 cycles.

Source files
------------

// File: rtl/cim_gemv_seq_if.sv
// ---------------------------------------------------------------------------
// cim_gemv_seq_if
//
// Command and operand/result stream bundle between the core's CIM path and
// the GeMV sequencer.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge
// where valid and ready are both 1. A source holds its payload stable while
// valid=1 and ready=0.
//
// Signals:
//   start      command strobe (host -> seq)
//   base_addr  row offset of the first chunk (host -> seq)
//   k_chunks   number of input words in the pass (host -> seq)
//   abort      synchronous cancel (host -> seq)
//   in_valid / in_ready / in_data      activation word stream (host -> seq)
//   out_valid / out_ready / out_data / out_idx  result stream (seq -> host)
//   busy       sequencer is in a pass (seq -> host)
//   done       one-cycle pass-complete pulse (seq -> host)
//
// Modports: master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface cim_gemv_seq_if #(
    parameter int K_WIDTH = 5
);
    logic               start;
    logic [6:0]         base_addr;
    logic [K_WIDTH-1:0] k_chunks;
    logic               abort;

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [2:0]         out_idx;

    logic               busy;
    logic               done;

    modport master (
        output start, base_addr, k_chunks, abort,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, busy, done
    );

    modport slave (
        input  start, base_addr, k_chunks, abort,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, busy, done
    );
endinterface

// File: rtl/cim_gemv_seq.sv
// ---------------------------------------------------------------------------
// cim_gemv_seq
//
// Sequencer for the 8-column compute-in-memory GeMV macro. Each command runs
// one matrix-vector pass: clear the eight macro accumulators, stream K packed
// activation words into the macro in accumulate mode, then drain the eight
// column results as a valid/ready stream.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   bus              command / input stream / output stream (slave side)
//   cim_cs           macro chip select
//   cim_write        macro write enable (always 0: no weight loading here)
//   cim_en           macro compute mode ('cim' pin)
//   cim_psum         macro accumulate enable ('partial_sum' pin)
//   cim_reset_out    macro accumulator clear ('reset_output' pin)
//   cim_output_reg   macro output register select
//   cim_address      macro row address
//   cim_input_data   macro activation word
//   cim_result       macro output mux value ('cim_output' pin)
//   state_dbg        current FSM state encoding, for observation only
//
// busy and done are registered alongside the state. All other outputs are
// decoded from registered state/counters, qualified by in_valid and abort.
// ---------------------------------------------------------------------------
module cim_gemv_seq #(
    parameter int K_WIDTH = 5,
    parameter int NUM_OUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    cim_gemv_seq_if.slave     bus,
    output logic              cim_cs,
    output logic              cim_write,
    output logic              cim_en,
    output logic              cim_psum,
    output logic              cim_reset_out,
    output logic [3:0]        cim_output_reg,
    output logic [31:0]       cim_address,
    output logic [31:0]       cim_input_data,
    input  logic [31:0]       cim_result,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // 128 rows consumed 8 per chunk: at most 16 chunks per pass.
    localparam logic [K_WIDTH-1:0] K_MAX    = K_WIDTH'(16);
    localparam logic [K_WIDTH-1:0] K_ONE    = K_WIDTH'(1);
    localparam logic [2:0]         J_LAST   = 3'(NUM_OUT - 1);

    state_t             state;
    logic [K_WIDTH-1:0] idx;      // chunks accepted so far
    logic [K_WIDTH-1:0] k_q;      // clamped chunk count of this pass
    logic [6:0]         base_q;   // row offset of chunk 0
    logic [2:0]         j;        // drain beat counter
    logic               busy_q;
    logic               done_q;

    logic [K_WIDTH-1:0] k_clamped;
    logic [6:0]         row_addr;
    logic               in_hs;
    logic               out_hs;

    assign k_clamped = (bus.k_chunks > K_MAX) ? K_MAX : bus.k_chunks;

    // 7-bit sum wraps past row 127 by construction.
    assign row_addr  = base_q + {idx[3:0], 3'b000};

    assign in_hs     = bus.in_valid  && bus.in_ready;
    assign out_hs    = bus.out_valid && bus.out_ready;

    // -----------------------------------------------------------------------
    // State machine with registered busy/done.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            k_q    <= '0;
            base_q <= '0;
            j      <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                // Abort wins over everything, including a start in IDLE.
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            base_q <= bus.base_addr;
                            k_q    <= k_clamped;
                            idx    <= '0;
                            j      <= '0;
                            state  <= S_CLEAR;
                            busy_q <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        state <= (k_q == '0) ? S_DRAIN : S_ACCUM;
                    end
                    S_ACCUM: begin
                        if (in_hs) begin
                            idx <= idx + K_ONE;
                            if (idx + K_ONE == k_q) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (out_hs) begin
                            j <= j + 3'd1;
                            if (j == J_LAST) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        // Start here is ignored; it is only sampled in IDLE.
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. In an abort cycle the handshake and macro strobes are
    // forced low so nothing is consumed or accumulated.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_idx    = '0;
        cim_cs         = 1'b0;
        cim_write      = 1'b0;
        cim_en         = 1'b0;
        cim_psum       = 1'b0;
        cim_reset_out  = 1'b0;
        cim_output_reg = '0;
        cim_address    = '0;
        cim_input_data = '0;
        case (state)
            S_CLEAR: begin
                cim_cs        = !bus.abort;
                cim_en        = 1'b1;
                cim_reset_out = 1'b1;
            end
            S_ACCUM: begin
                bus.in_ready   = !bus.abort;
                cim_en         = 1'b1;
                // Accumulate only on a handshake edge.
                cim_cs         = bus.in_valid && !bus.abort;
                cim_psum       = bus.in_valid && !bus.abort;
                cim_address    = {25'b0, row_addr};
                cim_input_data = bus.in_data;
            end
            S_DRAIN: begin
                cim_en         = 1'b1;
                // output_reg comes from the registered j, so the macro mux
                // and therefore out_data stay stable during backpressure.
                cim_output_reg = {1'b0, j};
                bus.out_valid  = !bus.abort;
                bus.out_data   = cim_result;
                bus.out_idx    = j;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_cim_gemv_seq.sv
// ---------------------------------------------------------------------------
// tb_cim_gemv_seq
//
// Directed bench for cim_gemv_seq with a behavioural model of the macro.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_cim_gemv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cim_cs, cim_write, cim_en, cim_psum, cim_reset_out;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address, cim_input_data, cim_result;
    logic [2:0]  state_dbg;

    cim_gemv_seq_if #(.K_WIDTH(5)) bus ();

    cim_gemv_seq #(.K_WIDTH(5), .NUM_OUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .cim_cs         (cim_cs),
        .cim_write      (cim_write),
        .cim_en         (cim_en),
        .cim_psum       (cim_psum),
        .cim_reset_out  (cim_reset_out),
        .cim_output_reg (cim_output_reg),
        .cim_address    (cim_address),
        .cim_input_data (cim_input_data),
        .cim_result     (cim_result),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- macro model ----------------
    // Every row of column c holds weight wt[c]. Per accumulate edge, each
    // column adds bits [14:9] of its dot product, sign-extended from 6 bits.
    logic [7:0]         wt [8];
    logic signed [15:0] acc [8];

    initial begin
        for (int c = 0; c < 8; c++) wt[c] = 8'h00;
        wt[1] = 8'h20;
        wt[3] = 8'h40;
    end

    function automatic logic signed [15:0] adc_val(input logic [31:0] d, input int c);
        int          dot;
        logic [31:0] dv;
        logic [5:0]  a;
        dot = 0;
        for (int r = 0; r < 8; r++) begin
            dot += int'(d[31-4*r -: 4]) * int'(wt[c]);
        end
        dv = 32'(dot);
        a  = dv[14:9];
        return {{10{a[5]}}, a};
    endfunction

    always @(posedge clk) begin
        if (cim_cs && cim_en && !cim_write) begin
            for (int c = 0; c < 8; c++) begin
                if (cim_reset_out)  acc[c] <= 16'sd0;
                else if (cim_psum)  acc[c] <= acc[c] + adc_val(cim_input_data, c);
            end
        end
    end

    assign cim_result = cim_en ? {{16{acc[cim_output_reg[2:0]][15]}}, acc[cim_output_reg[2:0]]} : 32'd0;

    // ---------------- monitor ----------------
    logic [31:0] acc_addr_q[$];
    logic [31:0] acc_data_q[$];
    logic [31:0] beat_idx_q[$];
    logic [31:0] beat_data_q[$];
    int done_cnt = 0;
    int clr_cnt  = 0;
    int busy_cyc = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (cim_cs && cim_en && cim_psum) begin
                acc_addr_q.push_back(cim_address);
                acc_data_q.push_back(cim_input_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                beat_idx_q.push_back({29'd0, bus.out_idx});
                beat_data_q.push_back(bus.out_data);
            end
            if (bus.done)      done_cnt <= done_cnt + 1;
            if (cim_reset_out) clr_cnt  <= clr_cnt + 1;
            if (bus.busy)      busy_cyc <= busy_cyc + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] word_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [6:0] b, input logic [4:0] k);
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = b; bus.k_chunks = k;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Sends every word in word_q; toggle=1 alternates in_valid each cycle.
    task automatic feed(input bit toggle);
        int budget = 200;
        bit ph = 1'b1;
        bit hs;
        while (word_q.size() > 0 && budget > 0) begin
            bus.in_valid = toggle ? ph : 1'b1;
            bus.in_data  = word_q[0];
            #1;
            hs = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (hs) void'(word_q.pop_front());
            ph = ~ph;
            budget--;
        end
        bus.in_valid = 1'b0;
        if (budget == 0) check("feed_timeout", 32'd0, 32'd1);
    endtask

    // Takes 8 beats; out_ready is held low stall_len cycles once stall_at
    // beats have been taken. Payload must hold while stalled.
    task automatic drain(input int stall_at, input int stall_len);
        int beats = 0, stalled = 0, budget = 100;
        bit held = 1'b0;
        logic [2:0]  h_idx;
        logic [31:0] h_data;
        while (beats < 8 && budget > 0) begin
            bus.out_ready = (beats == stall_at && stalled < stall_len) ? 1'b0 : 1'b1;
            if (!bus.out_ready) stalled++;
            #1;
            if (held) begin
                check("hold_idx", {29'd0, bus.out_idx}, {29'd0, h_idx});
                check("hold_data", bus.out_data, h_data);
            end
            held   = bus.out_valid && !bus.out_ready;
            h_idx  = bus.out_idx;
            h_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) beats++;
            @(negedge clk);
            budget--;
        end
        bus.out_ready = 1'b0;
        if (budget == 0) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int budget = 20;
        while (bus.busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_beat_order(input int b0);
        check("beat_count", 32'(beat_idx_q.size() - b0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (b0 + i < beat_idx_q.size())
                check("beat_idx", beat_idx_q[b0 + i], 32'(i));
        end
    endtask

    task automatic check_addrs(input int a0);
        int n = 0;
        while (exp_q.size() > 0) begin
            if (a0 + n < acc_addr_q.size())
                check("acc_addr", acc_addr_q[a0 + n], exp_q.pop_front());
            else
                check("acc_addr_missing", 32'd0, exp_q.pop_front());
            n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0, b0, d0, c0;
        logic [31:0] ordata;

        bus.start = 0; bus.base_addr = 0; bus.k_chunks = 0; bus.abort = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;

        // Reset state.
        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        check("rst_ctrl", {27'd0, cim_cs, cim_write, cim_en, cim_psum, cim_reset_out}, 32'd0);
        check("rst_bus", cim_address | cim_input_data | {28'd0, cim_output_reg}, 32'd0);
        check("rst_out", bus.out_data | {29'd0, bus.out_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted mid-ACCUM, then a fresh pass starts with one CLEAR.
        do_start(7'h00, 5'd4);
        #1 check("clear_pulse", {31'd0, cim_reset_out}, 32'd1);
        @(negedge clk);
        #1 check("in_accum", {29'd0, state_dbg}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_ctrl", {28'd0, bus.in_ready, cim_cs, cim_en, cim_psum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Addressing with stalls: base 0x10, K=3, in_valid toggling.
        a0 = acc_addr_q.size(); b0 = beat_idx_q.size(); c0 = clr_cnt;
        word_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        do_start(7'h10, 5'd3);
        feed(1'b1);
        #1;
        check("drain_after_k", {29'd0, state_dbg}, 32'd3);
        check("psum_edges", 32'(acc_addr_q.size() - a0), 32'd3);
        exp_q = '{32'h10, 32'h18, 32'h20};
        check_addrs(a0);
        if (a0 + 2 < acc_data_q.size()) check("acc_data2", acc_data_q[a0 + 2], 32'h3333_3333);
        drain(-1, 0);
        wait_idle();
        check("clear_once", 32'(clr_cnt - c0), 32'd1);
        check_beat_order(b0);

        // Wrap-around: base 0x78, K=2.
        a0 = acc_addr_q.size();
        word_q = '{32'hA, 32'hB};
        do_start(7'h78, 5'd2);
        feed(1'b0);
        exp_q = '{32'h78, 32'h00};
        check_addrs(a0);
        drain(-1, 0);
        wait_idle();

        // K=20 clamps to 16 handshakes; full-throughput pass is 26 cycles.
        a0 = acc_addr_q.size(); c0 = busy_cyc;
        for (int i = 0; i < 16; i++) word_q.push_back(32'(i));
        do_start(7'h00, 5'd20);
        feed(1'b0);
        #1;
        check("clamp_state", {29'd0, state_dbg}, 32'd3);
        check("clamp_count", 32'(acc_addr_q.size() - a0), 32'd16);
        if (a0 + 15 < acc_addr_q.size()) check("clamp_last_addr", acc_addr_q[a0 + 15], 32'h78);
        drain(-1, 0);
        wait_idle();
        check("k16_cycles", 32'(busy_cyc - c0), 32'd26);

        // End-to-end, twice: col3 = 30, col1 = 14, col0 = 0.
        for (int p = 0; p < 2; p++) begin
            b0 = beat_idx_q.size();
            word_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
            do_start(7'h00, 5'd2);
            feed(1'b0);
            drain(-1, 0);
            wait_idle();
            check_beat_order(b0);
            if (b0 + 3 < beat_data_q.size()) begin
                check("e2e_col0", beat_data_q[b0 + 0], 32'd0);
                check("e2e_col1", beat_data_q[b0 + 1], 32'd14);
                check("e2e_col3", beat_data_q[b0 + 3], 32'd30);
            end
        end

        // Drain backpressure: out_ready low 4 cycles at j=2.
        b0 = beat_idx_q.size(); d0 = done_cnt;
        word_q = '{32'hFFFF_FFFF};
        do_start(7'h00, 5'd1);
        feed(1'b0);
        drain(2, 4);
        wait_idle();
        @(negedge clk);
        check_beat_order(b0);
        check("bp_done_once", 32'(done_cnt - d0), 32'd1);
        if (b0 + 3 < beat_data_q.size()) check("bp_col3", beat_data_q[b0 + 3], 32'd15);

        // Abort in ACCUM after 1 of 4 handshakes.
        a0 = acc_addr_q.size(); d0 = done_cnt;
        do_start(7'h00, 5'd4);
        bus.in_valid = 1'b1; bus.in_data = 32'h5555_5555;
        @(negedge clk);
        #1 check("abort_pre_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.abort = 1'b1;
        #1;
        check("abort_cycle_ctrl", {29'd0, bus.in_ready, cim_cs, cim_psum}, 32'd0);
        @(negedge clk);
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        #1;
        check("abort_idle", {28'd0, bus.busy, state_dbg}, 32'd0);
        check("abort_hs", 32'(acc_addr_q.size() - a0), 32'd1);
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Start together with abort in IDLE is dropped.
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        #1 check("start_abort", {31'd0, bus.busy}, 32'd0);

        // K=0: CLEAR, eight zero beats, DONE -- 10 cycles.
        b0 = beat_idx_q.size(); c0 = busy_cyc;
        do_start(7'h00, 5'd0);
        drain(-1, 0);
        wait_idle();
        check("k0_cycles", 32'(busy_cyc - c0), 32'd10);
        check_beat_order(b0);
        ordata = 32'd0;
        for (int i = b0; i < beat_data_q.size(); i++) ordata |= beat_data_q[i];
        check("k0_zero_data", ordata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
